// File: rtl/load_store_unit.sv
// load_store_unit: RV32 memory stage. It captures one data access from execute
// and runs it through a valid/ready request and response handshake with data
// memory, holding the pipeline until the access completes. Load data comes back
// shifted into place and sign- or zero-extended.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned and
// size-3 accesses. Without it, misaligned addresses are forced aligned and
// size 3 runs as a word access.
module load_store_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic        ex_data_req,
    input  logic        ex_data_wr,
    input  logic [1:0]  ex_data_byte,
    input  logic        ex_zero_extnd,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_misalign,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        zext_q, zext_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;

    logic        capture;
    logic        fault;
    logic [1:0]  size_c;
    logic [1:0]  off_c;
    logic [31:0] wdata_c;
    logic [3:0]  wstrb_c;
    logic [31:0] rsp_sh;

    assign capture = (state_q == IDLE) & ex_valid & ex_data_req;
    assign rsp_sh  = mem_rsp_rdata >> {off_q, 3'b000};

    // Decode the incoming access: effective size, lane offset, replicated store data and strobes
    always_comb begin
        fault  = 1'b0;
        size_c = (ex_data_byte == 2'd3) ? 2'd2 : ex_data_byte;
`ifdef LSU_MISALIGN_TRAP_EN
        fault = ((ex_data_byte == 2'd1) && ex_addr[0]) ||
                ((ex_data_byte == 2'd2) && (ex_addr[1:0] != 2'd0)) ||
                (ex_data_byte == 2'd3);
`endif
        // Offsets below already drop the low bits a half/word cannot use, which
        // is the forced alignment when trapping is off.
        case (size_c)
            2'd0: begin
                off_c   = ex_addr[1:0];
                wdata_c = {4{ex_wdata[7:0]}};
                wstrb_c = 4'b0001 << ex_addr[1:0];
            end
            2'd1: begin
                off_c   = {ex_addr[1], 1'b0};
                wdata_c = {2{ex_wdata[15:0]}};
                wstrb_c = 4'b0011 << {ex_addr[1], 1'b0};
            end
            default: begin
                off_c   = 2'd0;
                wdata_c = ex_wdata;
                wstrb_c = 4'hF;
            end
        endcase
        if (!ex_data_wr) wstrb_c = 4'h0;
    end

    // State register and all datapath flops
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            off_q      <= '0;
            size_q     <= '0;
            zext_q     <= 1'b0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            off_q      <= off_d;
            size_q     <= size_d;
            zext_q     <= zext_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (capture) state_d = fault ? DONE : REQ;
            REQ:  if (mem_req_ready) state_d = wr_q ? DONE : RSP;
            RSP:  if (mem_rsp_valid) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: capture the request, clear data on stores and faults, extend load data
    always_comb begin
        addr_d     = addr_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        off_d      = off_q;
        size_d     = size_q;
        zext_d     = zext_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        if (capture) begin
            addr_d     = {ex_addr[31:2], 2'b00};
            wr_d       = ex_data_wr;
            wdata_d    = wdata_c;
            wstrb_d    = wstrb_c;
            off_d      = off_c;
            size_d     = size_c;
            zext_d     = ex_zero_extnd;
            misalign_d = fault;
            if (fault) rdata_d = '0;
        end
        if ((state_q == REQ) && mem_req_ready && wr_q) rdata_d = '0;
        if ((state_q == RSP) && mem_rsp_valid) begin
            case (size_q)
                2'd0:    rdata_d = {{24{~zext_q & rsp_sh[7]}}, rsp_sh[7:0]};
                2'd1:    rdata_d = {{16{~zext_q & rsp_sh[15]}}, rsp_sh[15:0]};
                default: rdata_d = rsp_sh;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        mem_req_valid = (state_q == REQ);
        lsu_done      = (state_q == DONE);
        lsu_stall     = ex_valid & ex_data_req & (state_q != DONE);
    end

    assign lsu_rdata     = rdata_q;
    assign lsu_misalign  = misalign_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wr    = wr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized accesses against a
// byte-lane reference model and a 256-word memory model. Honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ex_valid, ex_data_req, ex_data_wr, ex_zero_extnd;
    logic [1:0]  ex_data_byte;
    logic [31:0] ex_addr, ex_wdata;
    logic        lsu_stall, lsu_done, lsu_misalign;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_wr;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .resetn(resetn),
        .ex_valid(ex_valid), .ex_data_req(ex_data_req), .ex_data_wr(ex_data_wr),
        .ex_data_byte(ex_data_byte), .ex_zero_extnd(ex_zero_extnd),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .lsu_misalign(lsu_misalign),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wr(mem_req_wr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference: what the access should look like, built byte by byte
    function automatic void model(input logic wr, input logic [1:0] sz, input logic zx,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic flt, output logic [31:0] ea,
                                  output logic [31:0] ewd, output logic [3:0] es,
                                  output logic [31:0] erd);
        int n;
        int off;
        logic [31:0] word;
        flt = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        flt = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
`endif
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ea  = a - (a % n);
        off = ea % 4;
        ewd = '0;
        es  = '0;
        erd = '0;
        for (int l = 0; l < 4; l++) ewd[8*l +: 8] = wd[8*(l % n) +: 8];
        if (wr) begin
            for (int k = 0; k < n; k++) es[off+k] = 1'b1;
        end else begin
            word = mem[ea[9:2]];
            for (int k = 0; k < n; k++) erd[8*k +: 8] = word[8*(off+k) +: 8];
            if (n < 4 && !zx && erd[8*n-1])
                for (int k = n; k < 4; k++) erd[8*k +: 8] = 8'hFF;
        end
        ea = ea & 32'hFFFF_FFFC;
    endfunction

    // One full access; returns the cycle index (from capture) of lsu_done
    task automatic run_access(input logic wr, input logic [1:0] sz, input logic zx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int rd, input int pd, output int lat);
        logic flt;
        logic [31:0] ea, ewd, erd;
        logic [3:0] es;
        int cyc;
        model(wr, sz, zx, a, wd, flt, ea, ewd, es, erd);
        @(negedge clk);
        ex_valid = 1'b1; ex_data_req = 1'b1; ex_data_wr = wr; ex_data_byte = sz;
        ex_zero_extnd = zx; ex_addr = a; ex_wdata = wd;
        mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom); mem_rsp_rdata = $urandom;
        #1;
        chk("stall_c0", lsu_stall, 1);
        chk("done_c0", lsu_done, 0);
        chk("reqv_c0", mem_req_valid, 0);
        @(negedge clk);
        cyc = 1;
        if (flt) begin
            mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom);
            #1;
            chk("flt_done", lsu_done, 1);
            chk("flt_misalign", lsu_misalign, 1);
            chk("flt_reqv", mem_req_valid, 0);
            chk("flt_stall", lsu_stall, 0);
        end else begin
            for (int i = 0; i <= rd; i++) begin
                mem_req_ready = (i == rd); mem_rsp_valid = 1'($urandom); mem_rsp_rdata = $urandom;
                #1;
                chk("req_valid", mem_req_valid, 1);
                chk("req_addr", mem_req_addr, ea);
                chk("req_wr", mem_req_wr, wr);
                chk("req_wdata", mem_req_wdata, ewd);
                chk("req_wstrb", mem_req_wstrb, es);
                chk("req_stall", lsu_stall, 1);
                chk("req_done", lsu_done, 0);
                @(negedge clk);
                cyc++;
            end
            if (wr) begin
                for (int l = 0; l < 4; l++)
                    if (es[l]) mem[ea[9:2]][8*l +: 8] = ewd[8*l +: 8];
            end else begin
                for (int j = 0; j <= pd; j++) begin
                    mem_rsp_valid = (j == pd);
                    mem_rsp_rdata = (j == pd) ? mem[ea[9:2]] : $urandom;
                    mem_req_ready = 1'($urandom);
                    #1;
                    chk("rsp_reqv", mem_req_valid, 0);
                    chk("rsp_stall", lsu_stall, 1);
                    chk("rsp_done", lsu_done, 0);
                    @(negedge clk);
                    cyc++;
                end
            end
            mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom); mem_rsp_rdata = $urandom;
            #1;
            chk("done", lsu_done, 1);
            chk("done_misalign", lsu_misalign, 0);
            chk("done_stall", lsu_stall, 0);
            chk("done_rdata", lsu_rdata, erd);
        end
        lat = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ex_valid = 1'($urandom); ex_data_req = ~ex_valid & 1'($urandom);
            mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom);
            #1;
            chk("idle_stall", lsu_stall, 0);
            chk("idle_done", lsu_done, 0);
            chk("idle_reqv", mem_req_valid, 0);
        end
    endtask

    initial begin
        int lat;
        logic [31:0] prev;
        resetn = 1'b0;
        ex_valid = 0; ex_data_req = 0; ex_data_wr = 0; ex_data_byte = 0; ex_zero_extnd = 0;
        ex_addr = 0; ex_wdata = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        #1;
        chk("rst_reqv", mem_req_valid, 0);
        chk("rst_done", lsu_done, 0);
        chk("rst_misalign", lsu_misalign, 0);
        chk("rst_rdata", lsu_rdata, 0);
        chk("rst_stall", lsu_stall, 0);
        chk("rst_addr", mem_req_addr, 0);
        chk("rst_wdata", mem_req_wdata, 0);
        chk("rst_wstrb", mem_req_wstrb, 0);
        chk("rst_wr", mem_req_wr, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // LB sign/zero extension
        mem[8'h40] = 32'h80FF7F01;
        run_access(0, 2'd0, 0, 32'h102, 0, 0, 0, lat);
        chk("lb_sext", lsu_rdata, 32'hFFFFFFFF);
        chk("lb_lat", lat, 3);
        run_access(0, 2'd0, 1, 32'h102, 0, 0, 0, lat);
        chk("lbu_zext", lsu_rdata, 32'h000000FF);
        idle(1);
        // SH upper half
        run_access(1, 2'd1, 0, 32'h206, 32'h0000BEEF, 0, 0, lat);
        chk("sh_lat", lat, 2);
        prev = lsu_rdata;
        idle(2);
        chk("rdata_hold", lsu_rdata, prev);
        // Back-pressure on both handshakes
        run_access(0, 2'd2, 0, 32'h100, 0, 3, 2, lat);
        chk("bp_lat", lat, 8);
        chk("bp_rdata", lsu_rdata, 32'h80FF7F01);
        // Misaligned LW
        run_access(0, 2'd2, 0, 32'h101, 0, 0, 0, lat);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_lat", lat, 1);
`else
        chk("mis_lat", lat, 3);
        chk("mis_rdata", lsu_rdata, 32'h80FF7F01);
`endif
        // Back-to-back LW then SW (REQ of the second is checked at its c1)
        run_access(0, 2'd2, 0, 32'h104, 0, 0, 0, lat);
        run_access(1, 2'd2, 0, 32'h108, 32'h12345678, 0, 0, lat);
        chk("b2b_sw_lat", lat, 2);

        // Reset while waiting in RSP
        @(negedge clk);
        ex_valid = 1; ex_data_req = 1; ex_data_wr = 0; ex_data_byte = 2'd2; ex_addr = 32'h100;
        mem_req_ready = 1; mem_rsp_valid = 0;
        @(negedge clk);
        @(negedge clk);
        mem_req_ready = 0;
        #1 resetn = 1'b0;
        #1;
        chk("mid_rst_reqv", mem_req_valid, 0);
        chk("mid_rst_done", lsu_done, 0);
        chk("mid_rst_rdata", lsu_rdata, 0);
        chk("mid_rst_stall", lsu_stall, 1);
        @(negedge clk);
        ex_valid = 0;
        resetn = 1'b1;
        run_access(0, 2'd1, 1, 32'h102, 0, 1, 1, lat);
        chk("post_rst_lat", lat, 5);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            run_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 1023),
                       $urandom, $urandom_range(0, 2), $urandom_range(0, 2), lat);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
